// File: rtl/pipe_run_ctrl.sv
// Run controller for the 4-stage 8-bit core: loads the program into IMEM,
// then sequences run / single-step / halt by driving PC enable, PC clear and IF/ID flush.
module pipe_run_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              jump_taken,
  output logic              pc_en,
  output logic              pc_rst,
  output logic              if_id_flush,
  output logic              busy,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  issued_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam int DRAIN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH - 1);
  localparam logic [ADDR_W-1:0]  PTR_LAST   = '1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   issued_inc;

  // Saturating increment so a long free-run never wraps the count back to zero.
  assign issued_inc = (&issued_q) ? issued_q : issued_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      drain_q  <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      drain_q  <= drain_d;
      issued_q <= issued_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    drain_d  = drain_q;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          ptr_d    = '0;
          issued_d = '0;
        end else if (step) begin
          state_d = ST_STEP;
        end else if (run) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        // The last address ends the load instead of wrapping onto address 0.
        if (load_valid) begin
          if (load_last || ptr_q == PTR_LAST) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        issued_d = issued_inc;
        if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_STEP: begin
        issued_d = issued_inc;
        state_d  = ST_DRAIN;
        drain_d  = DRAIN_INIT;
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_rst      = 1'b1;
    pc_en       = 1'b0;
    if_id_flush = 1'b1;
    load_ready  = 1'b0;
    busy        = 1'b0;
    imem_we     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        imem_we    = load_valid;
      end
      ST_RUN, ST_STEP: begin
        pc_rst      = 1'b0;
        pc_en       = 1'b1;
        if_id_flush = jump_taken;
        busy        = 1'b1;
      end
      ST_DRAIN: begin
        pc_rst = 1'b0;
        busy   = 1'b1;
      end
      ST_HALTED: pc_rst = 1'b0;
      default: ;
    endcase
  end

  assign imem_addr  = ptr_q;
  assign imem_wdata = load_data;
  assign state      = state_q;
  assign issued_cnt = issued_q;

endmodule
